quad_encoder_bank: RTL

//  - Parametrised multi-channel quadrature encoder interface for the CS3710 processor's I/O space.
//  - Each channel synchronises and debounces its A/B pins, then decodes Gray-code transitions.
//  - Each channel keeps a signed position counter, in 1x (per detent) or 4x (per edge) resolution.
//  - Counters and sticky status are read and written through a simple en/write/addr bus.

---
 rtl/quad_encoder_bank_pkg.sv | 14 +
 rtl/quad_encoder_bank_if.sv | 13 +
 rtl/quad_encoder_bank_channel.sv | 88 ++++++++
 rtl/quad_encoder_bank.sv | 55 +++++
 4 files changed

// File: rtl/quad_encoder_bank_pkg.sv
// quad_encoder_bank_pkg: register map, status bit positions and Gray states shared by the encoder bank
package quad_encoder_bank_pkg;
    localparam logic REG_COUNT  = 1'b0;
    localparam logic REG_STATUS = 1'b1;
    localparam int ST_ERR    = 0;
    localparam int ST_SAT    = 1;
    localparam int ST_DIR    = 2;
    localparam int ST_PRIMED = 3;
    typedef enum logic [1:0] {S00 = 2'b00, S01 = 2'b01, S11 = 2'b11, S10 = 2'b10} gray_e;
    // {A,B} that follows s when A leads B, i.e. the increment direction
    function automatic logic [1:0] cw_next(input logic [1:0] s);
        return s == S00 ? S10 : s == S10 ? S11 : s == S11 ? S01 : S00;
    endfunction
endpackage

// File: rtl/quad_encoder_bank_if.sv
// quad_encoder_bank_if: en/write/addr register bus of the encoder bank
interface quad_encoder_bank_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 2
);
    logic             en;
    logic             write;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;
    modport master (output en, write, addr, writedata, input readdata);
    modport slave  (input en, write, addr, writedata, output readdata);
endinterface

// File: rtl/quad_encoder_bank_channel.sv
// quad_channel: pin synchroniser, debounce filter, Gray decoder, position counter and
// sticky status for one encoder channel.
module quad_channel
    import quad_encoder_bank_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 4,
    parameter int X4         = 0,
    parameter int SATURATE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             cnt_we_i,
    input  logic             st_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] status_o,
    output logic             step_o,
    output logic             dir_o
);
    localparam int RW = $clog2(FILTER_LEN + 1);
    localparam logic [WIDTH-1:0] CMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] CMIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic [1:0]       meta_q, sync_q, cand_q, filt_q, dec_q;
    logic [RW-1:0]    run_q, run_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             filt_v_q, primed_q, err_q, err_d, sat_q, sat_d, dir_q, dir_d, step_q;
    logic             accept, change, valid, inc, hit, at_lim;

    always_comb begin
        run_d    = sync_q != cand_q ? RW'(1) : run_q == RW'(FILTER_LEN) ? run_q : run_q + RW'(1);
        accept   = run_q == RW'(FILTER_LEN) && (!filt_v_q || cand_q != filt_q);
        change   = primed_q && filt_q != dec_q;
        valid    = change && ^(filt_q ^ dec_q);
        inc      = filt_q == cw_next(dec_q);
        // 1x mode counts only on filtered A rising; a bus write to COUNT swallows the step
        hit      = valid && (X4 != 0 || (!dec_q[1] && filt_q[1])) && !cnt_we_i;
        at_lim   = SATURATE != 0 && cnt_q == (inc ? CMAX : CMIN);
        cnt_d    = cnt_we_i ? wdata_i : hit && !at_lim ? (inc ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1)) : cnt_q;
        dir_d    = hit ? inc : dir_q;
        err_d    = (change && !valid) || (err_q && !(st_we_i && wdata_i[ST_ERR]));
        sat_d    = (hit && at_lim) || (sat_q && !(st_we_i && wdata_i[ST_SAT]));
        status_o = '0;
        status_o[ST_ERR]    = err_q;
        status_o[ST_SAT]    = sat_q;
        status_o[ST_DIR]    = dir_q;
        status_o[ST_PRIMED] = primed_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            cand_q   <= '0;
            run_q    <= '0;
            filt_q   <= '0;
            filt_v_q <= 1'b0;
            dec_q    <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            meta_q   <= {a_i, b_i};
            sync_q   <= meta_q;
            cand_q   <= sync_q;
            run_q    <= run_d;
            if (accept) begin
                filt_q   <= cand_q;
                filt_v_q <= 1'b1;
            end
            dec_q    <= filt_q;
            primed_q <= primed_q || filt_v_q;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
            dir_q    <= dir_d;
            step_q   <= hit;
        end

    assign count_o = cnt_q;
    assign step_o  = step_q;
    assign dir_o   = dir_q;
endmodule

// File: rtl/quad_encoder_bank.sv
// quad_encoder_bank: bank of quadrature encoder channels behind a COUNT/STATUS register bus;
// address is {channel, reg}, out-of-range channels read 0 and ignore writes.
module quad_encoder_bank
    import quad_encoder_bank_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 4,
    parameter int X4         = 0,
    parameter int SATURATE   = 0,
    localparam int AW        = $clog2(CHANNELS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] rot_a_i,
    input  logic [CHANNELS-1:0] rot_b_i,
    quad_encoder_bank_if.slave  bus,
    output logic [CHANNELS-1:0] step_o,
    output logic [CHANNELS-1:0] dir_o
);
    logic [WIDTH-1:0] count [CHANNELS];
    logic [WIDTH-1:0] status [CHANNELS];
    logic [WIDTH-1:0] rdata;
    logic [AW-1:0]    ch;
    logic             wr;

    assign ch = AW'(bus.addr >> 1);
    assign wr = bus.en && bus.write;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        quad_channel #(
            .WIDTH(WIDTH), .FILTER_LEN(FILTER_LEN), .X4(X4), .SATURATE(SATURATE)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .a_i(rot_a_i[c]),
            .b_i(rot_b_i[c]),
            .cnt_we_i(wr && ch == AW'(c) && bus.addr[0] == REG_COUNT),
            .st_we_i(wr && ch == AW'(c) && bus.addr[0] == REG_STATUS),
            .wdata_i(bus.writedata),
            .count_o(count[c]),
            .status_o(status[c]),
            .step_o(step_o[c]),
            .dir_o(dir_o[c])
        );
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (ch == AW'(c)) rdata = bus.addr[0] == REG_STATUS ? status[c] : count[c];
    end

    assign bus.readdata = rdata;
endmodule
